// File: rtl/fetch_seq.sv
// fetch_seq: sequences a short program out of an instruction memory, one
// word at a time. Each word is requested, captured from the memory's
// registered output, decoded into ALU fields, and held until the ALU
// accepts it.
//
// Ports:
//   clk, rst           - clock; synchronous active-high reset
//   start              - single-cycle request to begin a run (IDLE/DONE only)
//   mem_en, mem_addr   - instruction memory read enable / address (= PC)
//   data_frame[12:0]   - registered memory word {a[3:0], b[3:0], c, op[3:0]}
//   a_out, b_out,
//   c_out, op_out      - decoded fields, change only on WAIT->HOLD or reset
//   out_valid          - fields valid (HOLD state)
//   out_ready          - ALU accepts fields
//   busy, done         - run in progress / run complete
//
// Build option: define FETCH_LOOP_EN to wrap PC back to 0 after LAST_ADDR
// and keep running until reset; otherwise the run ends in DONE.

module fetch_seq #(
    parameter int                ADDR_W    = 3,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 3'd5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [12:0]       data_frame,
    output logic [3:0]        a_out,
    output logic [3:0]        b_out,
    output logic              c_out,
    output logic [3:0]        op_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= '0;
            a_out  <= '0;
            b_out  <= '0;
            c_out  <= 1'b0;
            op_out <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            // The memory word is valid during WAIT; capture it as we leave.
            // A reset during WAIT skips this, so a stale frame is dropped.
            if (state == WAIT) begin
                a_out  <= data_frame[12:9];
                b_out  <= data_frame[8:5];
                c_out  <= data_frame[4];
                op_out <= data_frame[3:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        case (state)
            IDLE: begin
                if (start) state_nx = REQ;
            end
            REQ:  state_nx = WAIT;
            WAIT: state_nx = HOLD;
            HOLD: begin
                if (out_ready) begin
                    if (pc == LAST_ADDR) begin
`ifdef FETCH_LOOP_EN
                        pc_nx    = '0;
                        state_nx = REQ;
`else
                        state_nx = DONE;
`endif
                    end else begin
                        pc_nx    = pc + ADDR_W'(1);
                        state_nx = REQ;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    pc_nx    = '0;
                    state_nx = REQ;
                end
            end
            default: begin
                pc_nx    = '0;
                state_nx = IDLE;
            end
        endcase
    end

    assign mem_en    = (state == REQ);
    assign mem_addr  = pc;
    assign out_valid = (state == HOLD);
    assign busy      = (state == REQ) || (state == WAIT) || (state == HOLD);
    assign done      = (state == DONE);

endmodule
